grey_colorize: RTL and testbench
================================

// Module: grey_colorize
// PURPOSE
//  Inverse-direction companion to the greyscale stage in the video path: consumes greyscale
//  pixel stream (grey replicated in all three channel slots) and re-expands it to RGB via a
//  fixed "heat" colormap. AXI4-Stream-style slave in, master out; 3-stage pipeline with stall.
//  Sits after greyscale filter, before VDMA/output formatter.
// PARAMETERS
//  COLOR_WIDTH  8   bits per colour channel (W); M = 2^W-1
//  FCNT_WIDTH   16  width of frame_count
// PORTS
//  clk            in   1      clock
//  aresetn        in   1      asynchronous, active-low reset
//  s_tdata        in   3W     input pixel {R[3W-1:2W],B[2W-1:W],G[W-1:0]}; grey taken from G slot
//  s_tvalid       in   1      input beat valid
//  s_tready       out  1      input beat accepted when s_tvalid&s_tready
//  s_tuser        in   1      start-of-frame marker
//  s_tlast        in   1      end-of-line marker
//  m_tdata        out  3W     output RGB, same channel packing as s_tdata
//  m_tvalid       out  1      output beat valid
//  m_tready       in   1      downstream ready
//  m_tuser        out  1      SOF, aligned with m_tdata
//  m_tlast        out  1      EOL, aligned with m_tdata
//  frame_count    out  FCNT_WIDTH  count of SOF beats transferred on master side
//  bypass         in   1      (only with COLORIZE_BYPASS_EN) pass grey through uncoloured
// BEHAVIOUR
//  - Reset: all stage valids 0, m_tdata/m_tuser/m_tlast 0, frame_count 0, s_tready 1 after reset.
//  - Global enable en = !m_tvalid | m_tready; all 3 stages advance together when en=1.
//  - s_tready = en (combinational from m_tready; accepted design choice).
//  - Stage1: capture g=s_tdata[W-1:0], tuser, tlast, valid=s_tvalid.
//  - Stage2: t=3*g (W+2 bits, no overflow); r_raw=t, g_raw=t-M, b_raw=t-2M (signed, W+3 bits).
//  - Stage3: sat each to [0,M]: <0 -> 0, >M -> M; pack {R,B,G} into m_tdata.
//  - Latency: 3 clk from accept to m_tvalid with m_tready held 1; throughput 1 pixel/clk.
//  - Bubbles (s_tvalid=0) propagate as invalid stages; not collapsed.
//  - m_tready=0 with m_tvalid=1: m_tdata/tuser/tlast/tvalid held stable, s_tready=0, no beat lost.
//  - tuser/tlast travel with their pixel unchanged; never reordered or dropped.
//  - frame_count += 1 on each m_tvalid&m_tready&m_tuser; wraps 2^FCNT_WIDTH-1 -> 0.
//  - Reset asserted mid-stream: in-flight pixels discarded, no partial output after deassert.
//  - g=0 -> RGB 0,0,0; g=M -> M,M,M; mapping monotonic per channel.
// CONFIGURATION
//  COLORIZE_BYPASS_EN defined: bypass port exists; bypass sampled at stage2 per pixel; when 1,
//   stage3 output = {g,g,g} (grey replicated), latency unchanged.
//  Not defined: no bypass port; colormap always applied.
// TESTING
//  - Reset: aresetn low mid-frame -> m_tvalid=0, frame_count=0, m_tdata=0; s_tready=1 after release.
//  - W=8, feed g=0,85,128,200,255 back-to-back, m_tready=1 -> outputs {R,B,G} =
//    {0,0,0},{255,0,0},{255,0,129},{255,90,255},{255,255,255} at cycles 3..7.
//  - Backpressure: m_tready=0 for 5 cycles after first output -> output held, s_tready=0,
//    all 5 pixels delivered in order, none duplicated.
//  - Sideband: tuser on pixel 0, tlast on pixel 3 -> appear on same output beats; frame_count=1.
//  - Wrap: FCNT_WIDTH=2, 5 SOF beats -> frame_count sequence 1,2,3,0,1.
//  - With COLORIZE_BYPASS_EN: bypass=1, g=128 -> {128,128,128}; toggle to 0 -> {255,0,129}.

Source files
------------

// File: rtl/grey_colorize.sv
// grey_colorize: re-expands a greyscale pixel stream to RGB through a fixed "heat" colormap.
//
// Three-stage AXI4-Stream style pipeline (slave in, master out) with a single global stall.
//   clk          clock
//   aresetn      asynchronous active-low reset
//   s_tdata      input pixel {R,B,G}; only the G slot (grey) is used
//   s_tvalid     input beat valid
//   s_tready     input ready (combinational from m_tready)
//   s_tuser      start-of-frame marker in
//   s_tlast      end-of-line marker in
//   m_tdata      output pixel {R,B,G}
//   m_tvalid     output beat valid
//   m_tready     downstream ready
//   m_tuser      start-of-frame marker out, aligned with m_tdata
//   m_tlast      end-of-line marker out, aligned with m_tdata
//   frame_count  number of SOF beats transferred on the master side (wraps)
//   bypass       (COLORIZE_BYPASS_EN only) pass the grey value through uncoloured
//
// Optional feature macro: COLORIZE_BYPASS_EN adds the bypass port.
module grey_colorize #(
    parameter int COLOR_WIDTH = 8,
    parameter int FCNT_WIDTH  = 16
) (
    input  logic                     clk,
    input  logic                     aresetn,
    input  logic [3*COLOR_WIDTH-1:0] s_tdata,
    input  logic                     s_tvalid,
    output logic                     s_tready,
    input  logic                     s_tuser,
    input  logic                     s_tlast,
    output logic [3*COLOR_WIDTH-1:0] m_tdata,
    output logic                     m_tvalid,
    input  logic                     m_tready,
    output logic                     m_tuser,
    output logic                     m_tlast,
`ifdef COLORIZE_BYPASS_EN
    input  logic                     bypass,
`endif
    output logic [FCNT_WIDTH-1:0]    frame_count
);
    localparam int W = COLOR_WIDTH;
    localparam logic [W+2:0] MAX = {3'b000, {W{1'b1}}};

    logic           en;
    logic           v1, u1, l1;
    logic [W-1:0]   g1;
    logic           v2, u2, l2;
    logic [W+2:0]   r2, gr2, b2;
    logic [W+2:0]   t;
    logic [3*W-1:0] pix;
    logic           unused_slots;
`ifdef COLORIZE_BYPASS_EN
    logic           byp2;
    logic [W-1:0]   g2;
`endif

    assign unused_slots = ^s_tdata[3*W-1:W];
    assign en = !m_tvalid || m_tready;
    assign s_tready = en;
    assign t = {3'b000, g1} + {2'b00, g1, 1'b0};

    // Raw values are two's complement in W+3 bits: top bit set means negative,
    // otherwise any of bits [W+1:W] set means the value exceeds M.
    function automatic logic [W-1:0] sat(input logic [W+2:0] x);
        return x[W+2] ? '0 : (|x[W+1:W]) ? '1 : x[W-1:0];
    endfunction

`ifdef COLORIZE_BYPASS_EN
    assign pix = byp2 ? {g2, g2, g2} : {sat(r2), sat(b2), sat(gr2)};
`else
    assign pix = {sat(r2), sat(b2), sat(gr2)};
`endif

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            {v1, u1, l1, g1} <= '0;
            {v2, u2, l2, r2, gr2, b2} <= '0;
            {m_tvalid, m_tuser, m_tlast, m_tdata} <= '0;
            frame_count <= '0;
`ifdef COLORIZE_BYPASS_EN
            byp2 <= 1'b0;
            g2 <= '0;
`endif
        end else begin
            if (en) begin
                v1 <= s_tvalid;
                u1 <= s_tuser;
                l1 <= s_tlast;
                g1 <= s_tdata[W-1:0];
                v2 <= v1;
                u2 <= u1;
                l2 <= l1;
                r2 <= t;
                gr2 <= t - MAX;
                b2 <= t - (MAX << 1);
`ifdef COLORIZE_BYPASS_EN
                byp2 <= bypass;
                g2 <= g1;
`endif
                m_tvalid <= v2;
                m_tuser <= u2;
                m_tlast <= l2;
                m_tdata <= pix;
            end
            if (m_tvalid && m_tready && m_tuser)
                frame_count <= frame_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_grey_colorize.sv
// tb_grey_colorize: directed self-checking bench for grey_colorize.
module tb_grey_colorize;
    logic        clk = 1'b0;
    logic        aresetn = 1'b0;
    logic [23:0] s_tdata = '0;
    logic        s_tvalid = 1'b0;
    logic        s_tready;
    logic        s_tuser = 1'b0;
    logic        s_tlast = 1'b0;
    logic [23:0] m_tdata;
    logic        m_tvalid;
    logic        m_tready = 1'b1;
    logic        m_tuser;
    logic        m_tlast;
    logic [1:0]  frame_count;
`ifdef COLORIZE_BYPASS_EN
    logic        bypass = 1'b0;
`endif

    int passed = 0;
    int total = 0;
    logic [7:0]  grey [5] = '{8'd0, 8'd85, 8'd128, 8'd200, 8'd255};
    logic [23:0] exp_rgb [5] = '{24'h000000, 24'hFF0000, 24'hFF0081, 24'hFF5AFF, 24'hFFFFFF};
    logic [1:0]  exp_fc [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

    grey_colorize #(.COLOR_WIDTH(8), .FCNT_WIDTH(2)) dut (
        .clk(clk),
        .aresetn(aresetn),
        .s_tdata(s_tdata),
        .s_tvalid(s_tvalid),
        .s_tready(s_tready),
        .s_tuser(s_tuser),
        .s_tlast(s_tlast),
        .m_tdata(m_tdata),
        .m_tvalid(m_tvalid),
        .m_tready(m_tready),
        .m_tuser(m_tuser),
        .m_tlast(m_tlast),
`ifdef COLORIZE_BYPASS_EN
        .bypass(bypass),
`endif
        .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    task tick;
        @(posedge clk);
        #1;
    endtask

    task do_reset;
        aresetn = 1'b0;
        s_tvalid = 1'b0;
        s_tuser = 1'b0;
        s_tlast = 1'b0;
        m_tready = 1'b1;
        tick;
        tick;
        aresetn = 1'b1;
        tick;
    endtask

    task test_reset;
        #1;
        total++; if (m_tvalid !== 1'b0) $display("FAIL reset_tvalid got %b want 0", m_tvalid); else passed++;
        total++; if (m_tdata !== 24'h0) $display("FAIL reset_tdata got %h want 000000", m_tdata); else passed++;
        total++; if (frame_count !== 2'd0) $display("FAIL reset_fcnt got %0d want 0", frame_count); else passed++;
        total++; if ({m_tuser, m_tlast} !== 2'b00) $display("FAIL reset_side got %b want 00", {m_tuser, m_tlast}); else passed++;
        tick;
        aresetn = 1'b1;
        tick;
        total++; if (s_tready !== 1'b1) $display("FAIL reset_tready got %b want 1", s_tready); else passed++;
    endtask

    task test_back_to_back;
        logic exp_v;
        s_tvalid = 1'b1;
        s_tdata = {3{grey[0]}};
        for (int n = 1; n <= 8; n++) begin
            tick;
            if (n < 5) s_tdata = {3{grey[n]}}; else s_tvalid = 1'b0;
            exp_v = (n >= 3 && n <= 7);
            total++; if (m_tvalid !== exp_v) $display("FAIL b2b_valid cycle %0d got %b want %b", n, m_tvalid, exp_v); else passed++;
            if (exp_v) begin
                total++; if (m_tdata !== exp_rgb[n-3]) $display("FAIL b2b_data cycle %0d got %h want %h", n, m_tdata, exp_rgb[n-3]); else passed++;
            end
        end
    endtask

    task test_backpressure;
        int in_idx, out_idx, stall;
        bit started;
        in_idx = 0;
        out_idx = 0;
        stall = 0;
        started = 1'b0;
        s_tvalid = 1'b1;
        s_tdata = {3{grey[0]}};
        m_tready = 1'b1;
        for (int c = 0; c < 25; c++) begin
            #1;
            if (!m_tready) begin
                total++; if (m_tvalid !== 1'b1 || m_tdata !== exp_rgb[out_idx]) $display("FAIL bp_hold cycle %0d got %b/%h want 1/%h", c, m_tvalid, m_tdata, exp_rgb[out_idx]); else passed++;
                total++; if (s_tready !== 1'b0) $display("FAIL bp_s_tready cycle %0d got %b want 0", c, s_tready); else passed++;
            end
            if (m_tvalid && m_tready) begin
                total++;
                if (out_idx >= 5) $display("FAIL bp_dup cycle %0d got extra beat %h want none", c, m_tdata);
                else if (m_tdata !== exp_rgb[out_idx]) $display("FAIL bp_order beat %0d got %h want %h", out_idx, m_tdata, exp_rgb[out_idx]);
                else passed++;
                out_idx++;
            end
            if (s_tvalid && s_tready) in_idx++;
            tick;
            s_tvalid = (in_idx < 5);
            if (in_idx < 5) s_tdata = {3{grey[in_idx]}};
            if (m_tvalid && !started) begin
                started = 1'b1;
                stall = 5;
            end
            m_tready = (stall == 0);
            if (stall > 0) stall--;
        end
        m_tready = 1'b1;
        total++; if (out_idx != 5) $display("FAIL bp_count got %0d want 5", out_idx); else passed++;
    endtask

    task test_sideband;
        logic exp_u, exp_l;
        do_reset;
        s_tvalid = 1'b1;
        s_tdata = {3{grey[0]}};
        s_tuser = 1'b1;
        for (int n = 1; n <= 8; n++) begin
            tick;
            if (n < 5) s_tdata = {3{grey[n]}}; else s_tvalid = 1'b0;
            s_tuser = 1'b0;
            s_tlast = (n == 3);
            if (n >= 3 && n <= 7) begin
                exp_u = (n == 3);
                exp_l = (n == 6);
                total++; if (m_tvalid !== 1'b1 || m_tuser !== exp_u || m_tlast !== exp_l) $display("FAIL side_beat %0d got v%b u%b l%b want v1 u%b l%b", n - 3, m_tvalid, m_tuser, m_tlast, exp_u, exp_l); else passed++;
            end
        end
        total++; if (frame_count !== 2'd1) $display("FAIL side_fcnt got %0d want 1", frame_count); else passed++;
    endtask

    task test_wrap;
        do_reset;
        s_tvalid = 1'b1;
        s_tuser = 1'b1;
        s_tdata = {3{grey[0]}};
        for (int n = 1; n <= 8; n++) begin
            tick;
            if (n < 5) s_tdata = {3{grey[n]}};
            else begin
                s_tvalid = 1'b0;
                s_tuser = 1'b0;
            end
            if (n >= 4) begin
                total++; if (frame_count !== exp_fc[n-4]) $display("FAIL wrap_fcnt cycle %0d got %0d want %0d", n, frame_count, exp_fc[n-4]); else passed++;
            end
        end
    endtask

    task test_reset_midstream;
        s_tvalid = 1'b1;
        s_tdata = {3{grey[2]}};
        for (int n = 0; n < 4; n++) tick;
        total++; if (m_tvalid !== 1'b1) $display("FAIL mid_pre_valid got %b want 1", m_tvalid); else passed++;
        aresetn = 1'b0;
        #1;
        total++; if (m_tvalid !== 1'b0) $display("FAIL mid_tvalid got %b want 0", m_tvalid); else passed++;
        total++; if (m_tdata !== 24'h0) $display("FAIL mid_tdata got %h want 000000", m_tdata); else passed++;
        total++; if (frame_count !== 2'd0) $display("FAIL mid_fcnt got %0d want 0", frame_count); else passed++;
        s_tvalid = 1'b0;
        tick;
        tick;
        aresetn = 1'b1;
        #1;
        total++; if (s_tready !== 1'b1) $display("FAIL mid_tready got %b want 1", s_tready); else passed++;
        for (int n = 0; n < 5; n++) begin
            tick;
            total++; if (m_tvalid !== 1'b0) $display("FAIL mid_partial cycle %0d got %b want 0", n, m_tvalid); else passed++;
        end
    endtask

`ifdef COLORIZE_BYPASS_EN
    task test_bypass;
        s_tvalid = 1'b1;
        s_tdata = 24'h808080;
        bypass = 1'b1;
        tick;
        tick;
        s_tvalid = 1'b0;
        bypass = 1'b0;
        tick;
        total++; if (m_tvalid !== 1'b1 || m_tdata !== 24'h808080) $display("FAIL byp_on got %b/%h want 1/808080", m_tvalid, m_tdata); else passed++;
        tick;
        total++; if (m_tvalid !== 1'b1 || m_tdata !== 24'hFF0081) $display("FAIL byp_off got %b/%h want 1/ff0081", m_tvalid, m_tdata); else passed++;
        tick;
    endtask
`endif

    initial begin
        test_reset;
        test_back_to_back;
        test_backpressure;
        test_sideband;
        test_wrap;
        test_reset_midstream;
`ifdef COLORIZE_BYPASS_EN
        test_bypass;
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
